wt_mem_responder: RTL and testbench

- Memory-side responder for the write-through L1 data-cache memory interface (request/ack in, return-valid out).
- Backed by an internal 64-bit-word memory array.
- Stands in for the AXI/L1.5 adapter plus memory in cache-only simulation and bring-up benches.
- Services cacheable line fills, non-cacheable word loads and byte-masked stores, one transaction at a time, echoing the transaction ID.

---
 rtl/wt_mem_responder.sv | 145 ++++++++++++++
 tb/tb_wt_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through dcache interface: services line fills,
// non-cacheable word loads and byte-masked stores from an internal 64-bit word array.
module wt_mem_responder #(
  parameter int NumWords  = 1024,
  parameter int LineWidth = 128,
  parameter int TidWidth  = 2,
  parameter int AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_data_req_i,
  output logic                 mem_data_ack_o,
  input  logic                 mem_data_rtype_i,
  input  logic                 mem_data_nc_i,
  input  logic [2:0]           mem_data_size_i,
  input  logic [TidWidth-1:0]  mem_data_tid_i,
  input  logic [AddrWidth-1:0] mem_data_paddr_i,
  input  logic [63:0]          mem_data_wdata_i,
  output logic                 mem_rtrn_vld_o,
  output logic                 mem_rtrn_type_o,
  output logic [LineWidth-1:0] mem_rtrn_data_o,
  output logic [TidWidth-1:0]  mem_rtrn_tid_o,
  output logic [1:0]           dbg_state_o
);

  localparam int N    = LineWidth / 64;
  localparam int IdxW = $clog2(NumWords);
  localparam int CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LineMask = ~IdxW'(N - 1);

  // Handshake: the request is consumed in the cycle where req and ack are both high;
  // ack is only given in IDLE. Returns are single-cycle pulses with no backpressure.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [TidWidth-1:0]   tid_q;
  logic                  type_q;
  logic                  nc_q;
  logic [IdxW-1:0]       idx_q;
  logic [CntW-1:0]       cnt_q;
  logic [LineWidth-1:0]  line_q;
  logic [63:0]           mem [NumWords];

  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] rd_idx;
  logic            accept;
  logic            last_beat;
  logic [7:0]      be_base;
  logic [15:0]     be_wide;
  logic [7:0]      be;
  logic            unused_addr;

  assign req_idx     = mem_data_paddr_i[3 +: IdxW];
  assign rd_idx      = idx_q + IdxW'(cnt_q);
  assign accept      = (state_q == IDLE) && mem_data_req_i;
  assign last_beat   = nc_q || (cnt_q == CntW'(N - 1));
  assign dbg_state_o = state_q;
  assign unused_addr = ^{mem_data_paddr_i[AddrWidth-1:3+IdxW]};

  // Lanes that spill past the 8-byte word are shifted out and dropped.
  always_comb begin
    be_base = 8'hff;
    case (mem_data_size_i)
      3'd0:    be_base = 8'h01;
      3'd1:    be_base = 8'h03;
      3'd2:    be_base = 8'h0f;
      default: be_base = 8'hff;
    endcase
    be_wide = {8'h00, be_base} << mem_data_paddr_i[2:0];
    be      = be_wide[7:0];
  end

  always_comb begin
    state_d         = state_q;
    mem_data_ack_o  = 1'b0;
    mem_rtrn_vld_o  = 1'b0;
    mem_rtrn_type_o = 1'b0;
    mem_rtrn_tid_o  = '0;
    mem_rtrn_data_o = '0;
    case (state_q)
      IDLE: begin
        mem_data_ack_o = mem_data_req_i;
        if (mem_data_req_i) state_d = mem_data_rtype_i ? RESP : READ;
      end
      READ: begin
        if (last_beat) state_d = RESP;
      end
      RESP: begin
        mem_rtrn_vld_o  = 1'b1;
        mem_rtrn_type_o = type_q;
        mem_rtrn_tid_o  = tid_q;
        mem_rtrn_data_o = type_q ? '0 : line_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tid_q   <= '0;
      type_q  <= 1'b0;
      nc_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tid_q  <= mem_data_tid_i;
        type_q <= mem_data_rtype_i;
        nc_q   <= mem_data_nc_i;
        idx_q  <= mem_data_nc_i ? req_idx : (req_idx & LineMask);
        cnt_q  <= '0;
        line_q <= '0;
      end else if (state_q == READ) begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CntW'(i)) line_q[64*i +: 64] <= mem[rd_idx];
        end
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Store data lands at the ack edge, so any later READ already sees it.
  always_ff @(posedge clk_i) begin
    if (accept && mem_data_rtype_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[req_idx][8*b +: 8] <= mem_data_wdata_i[8*b +: 8];
      end
    end
  end

  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_data_req_i && !mem_data_ack_o) |=> $stable({mem_data_rtype_i, mem_data_nc_i,
      mem_data_size_i, mem_data_tid_i, mem_data_paddr_i, mem_data_wdata_i}));

  a_size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_data_req_i |-> (mem_data_size_i <= 3'd3));

  a_rtrn_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rtrn_vld_o |=> !mem_rtrn_vld_o);

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder: vector table of single transactions plus
// hand-written back-to-back and reset-during-fill sequences.
module tb_wt_mem_responder;

  localparam int LW = 128;
  localparam int TW = 2;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          ack;
  logic          rtype;
  logic          nc;
  logic [2:0]    size;
  logic [TW-1:0] tid;
  logic [AW-1:0] paddr;
  logic [63:0]   wdata;
  logic          vld;
  logic          rtrn_type;
  logic [LW-1:0] rtrn_data;
  logic [TW-1:0] rtrn_tid;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] exp_q[$];

  typedef struct {
    logic          rtype;
    logic          nc;
    logic [2:0]    size;
    logic [TW-1:0] tid;
    logic [AW-1:0] paddr;
    logic [63:0]   wdata;
    int            lat;
    logic [LW-1:0] data;
  } vec_t;

  vec_t vecs[13];
  vec_t bb[3];
  logic [LW-1:0] bb_data[3];

  wt_mem_responder #(
    .NumWords(1024), .LineWidth(LW), .TidWidth(TW), .AddrWidth(AW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .mem_data_req_i   (req),
    .mem_data_ack_o   (ack),
    .mem_data_rtype_i (rtype),
    .mem_data_nc_i    (nc),
    .mem_data_size_i  (size),
    .mem_data_tid_i   (tid),
    .mem_data_paddr_i (paddr),
    .mem_data_wdata_i (wdata),
    .mem_rtrn_vld_o   (vld),
    .mem_rtrn_type_o  (rtrn_type),
    .mem_rtrn_data_o  (rtrn_data),
    .mem_rtrn_tid_o   (rtrn_tid),
    .dbg_state_o      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req   = 1'b1;
    rtype = v.rtype;
    nc    = v.nc;
    size  = v.size;
    tid   = v.tid;
    paddr = v.paddr;
    wdata = v.wdata;
  endtask

  task automatic idle_outputs(input string name);
    check({name, "_out"}, {ack, vld, rtrn_type, rtrn_tid, rtrn_data}, '0);
    check({name, "_state"}, LW'(dbg_state), LW'(0));
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    bit got;
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    check($sformatf("ack_v%0d", k), LW'(ack), LW'(1));
    @(posedge clk); #1;
    req = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (vld) begin
        got = 1'b1;
        lat = c;
      end
    end
    check($sformatf("lat_v%0d", k), LW'(lat), LW'(v.lat));
    if (got) begin
      check($sformatf("type_v%0d", k), LW'(rtrn_type), LW'(v.rtype));
      check($sformatf("tid_v%0d", k), LW'(rtrn_tid), LW'(v.tid));
      check($sformatf("data_v%0d", k), rtrn_data, v.data);
    end
    @(negedge clk);
    check($sformatf("vld_drop_v%0d", k), LW'(vld), LW'(0));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd3, 2'd0, 64'h40,   64'h0000000000000000, 1, '0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 2'd3, 64'h43,   64'h00000000AA000000, 1, '0};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 2'd1, 64'h40,   64'h0, 2, {64'h0, 64'h00000000AA000000}};
    vecs[3]  = '{1'b1, 1'b0, 3'd3, 2'd0, 64'h48,   64'hCAFEBABEDEADBEEF, 1, '0};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, 2'd2, 64'h40,   64'h1122334455667788, 1, '0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 2'd1, 64'h48,   64'h0, 3, {64'hCAFEBABEDEADBEEF, 64'h1122334455667788}};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 2'd0, 64'h46,   64'hA1B2C3D4E5F60718, 1, '0};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 2'd2, 64'h47,   64'h0, 2, {64'h0, 64'hA1B2334455667788}};
    vecs[8]  = '{1'b1, 1'b0, 3'd1, 2'd1, 64'h4A,   64'h0000000077660000, 1, '0};
    vecs[9]  = '{1'b1, 1'b0, 3'd3, 2'd2, 64'h4F,   64'h5500000000000000, 1, '0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 2'd3, 64'h40,   64'h0, 3, {64'h55FEBABE7766BEEF, 64'hA1B2334455667788}};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 2'd1, 64'h2058, 64'h0123456789ABCDEF, 1, '0};
    vecs[12] = '{1'b0, 1'b1, 3'd0, 2'd0, 64'h58,   64'h0, 2, {64'h0, 64'h0123456789ABCDEF}};

    bb[0] = '{1'b1, 1'b0, 3'd3, 2'd0, 64'h60, 64'h0F0E0D0C0B0A0908, 1, '0};
    bb[1] = '{1'b0, 1'b1, 3'd0, 2'd1, 64'h60, 64'h0, 2, '0};
    bb[2] = '{1'b1, 1'b0, 3'd3, 2'd2, 64'h68, 64'h0, 1, '0};
    bb_data[0] = '0;
    bb_data[1] = {64'h0, 64'h0F0E0D0C0B0A0908};
    bb_data[2] = '0;

    rst_n = 1'b0;
    req = 1'b0; rtype = 1'b0; nc = 1'b0; size = 3'd0; tid = '0; paddr = '0; wdata = '0;
    #2;
    idle_outputs("in_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      idle_outputs($sformatf("idle_c%0d", c));
    end

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // back-to-back with req held high across the whole burst
    begin
      int acks;
      int rets;
      int last_vld;
      bit prev_vld;
      bit acked;
      logic [TW-1:0] t;
      acks = 0; rets = 0; last_vld = -10; prev_vld = 1'b0;
      for (int i = 0; i < 3; i++) exp_q.push_back(bb[i].tid);
      @(posedge clk); #1;
      drive(bb[0]);
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (vld) begin
          check("b2b_no_consec", LW'(prev_vld), LW'(0));
          if (exp_q.size() == 0) begin
            check("b2b_extra_rtrn", LW'(1), LW'(0));
          end else begin
            t = exp_q.pop_front();
            check($sformatf("b2b_tid_%0d", rets), LW'(rtrn_tid), LW'(t));
            check($sformatf("b2b_data_%0d", rets), rtrn_data, bb_data[rets]);
            rets++;
          end
          last_vld = cyc;
        end
        prev_vld = vld;
        acked = ack;
        if (ack) begin
          if (acks > 0) check($sformatf("b2b_ack_gap_%0d", acks), LW'(cyc), LW'(last_vld + 1));
          acks++;
        end
        @(posedge clk); #1;
        if (acked) begin
          if (acks < 3) drive(bb[acks]);
          else req = 1'b0;
        end
      end
      check("b2b_acks", LW'(acks), LW'(3));
      check("b2b_q_empty", LW'(exp_q.size()), LW'(0));
    end

    // reset pulse during the second READ cycle of a line fill
    begin
      bit seen;
      vec_t fill;
      fill = '{1'b0, 1'b0, 3'd0, 2'd2, 64'h40, 64'h0, 3, '0};
      @(posedge clk); #1;
      drive(fill);
      @(negedge clk);
      check("rst_fill_ack", LW'(ack), LW'(1));
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      idle_outputs("rst_mid_read");
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (vld) seen = 1'b1;
      end
      check("rst_no_rtrn", LW'(seen), LW'(0));
      check("rst_state_idle", LW'(dbg_state), LW'(0));
      run_vec(vecs[12], 13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
